imm_arb: RTL

Two-port arbiter that shares one immediate generator (`imm_gen`) between two decode requesters. Each requester presents an immediate source field, selector and register operand. The arbiter grants one per cycle, round-robin. It computes the 64-bit immediate through an internal `imm_gen` instance and queues the tagged result in a small output FIFO for the consuming issue stage.

---
 rtl/imm_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imm_arb.sv
// Round-robin arbiter sharing one immediate generator between two decode ports, results queued in a tagged FIFO.
// Define IMM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins, no last-grant register).
module imm_arb #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_0,
  input  logic                     req_valid_1,
  output logic                     req_ready_0,
  output logic                     req_ready_1,
  input  logic [24:0]              req_src_0,
  input  logic [24:0]              req_src_1,
  input  logic [2:0]               req_sel_0,
  input  logic [2:0]               req_sel_1,
  input  logic [63:0]              req_regs_0,
  input  logic [63:0]              req_regs_1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_imm,
  output logic                     out_id,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [2:0] IMM_M    = 3'd1;
  localparam logic [2:0] IMM_BR   = 3'd2;
  localparam logic [2:0] IMM_LDI  = 3'd3;
  localparam logic [2:0] IMM_LDUI = 3'd4;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [63:0]   imm_mem_q [DEPTH];
  logic          id_mem_q  [DEPTH];

  logic          space, grant_0, grant_1, push, pop, sel_id;
  logic [24:0]   sel_src;
  logic [2:0]    sel_sel;
  logic [63:0]   sel_regs, gen_imm;
  logic          unused_bits;

  // Shared immediate generator; only the low source/register bits matter.
  function automatic logic [63:0] imm_gen(input logic [2:0]  sel,
                                          input logic [19:0] src,
                                          input logic [16:0] regs);
    logic [63:0] r;
    r = 64'd0;
    case (sel)
      IMM_M:    r = {{54{src[9]}}, src[9:0]};
      IMM_LDI:  r = {{44{src[19]}}, src[19:0]};
      IMM_LDUI: r = {32'd0, src[14:0], regs};
      IMM_BR:   r = {47'd0, src[16], 4'd0, src[15:4]};
      default:  r = 64'd0;
    endcase
    return r;
  endfunction

`ifdef IMM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_0 = req_valid_0;
    grant_1 = req_valid_1 & ~req_valid_0;
  end
`else
  logic last_q, last_d;

  // Contested cycles go to the port that was not accepted last.
  always_comb begin
    grant_0 = req_valid_0 & (~req_valid_1 | last_q);
    grant_1 = req_valid_1 & (~req_valid_0 | ~last_q);
  end
`endif

  always_comb begin
    space       = (occ_q < DEPTH_C);
    req_ready_0 = grant_0 & space & rst_n;
    req_ready_1 = grant_1 & space & rst_n;
    push        = (req_valid_0 & req_ready_0) | (req_valid_1 & req_ready_1);
    out_valid   = (occ_q != '0);
    pop         = out_valid & out_ready;
    sel_id      = grant_1;
    sel_src     = sel_id ? req_src_1  : req_src_0;
    sel_sel     = sel_id ? req_sel_1  : req_sel_0;
    sel_regs    = sel_id ? req_regs_1 : req_regs_0;
    gen_imm     = imm_gen(sel_sel, sel_src[19:0], sel_regs[16:0]);
  end

  assign unused_bits = ^{sel_src[24:20], sel_regs[63:17]};

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

`ifndef IMM_ARB_FIXED_PRIO_EN
  always_comb begin
    last_d = last_q;
    if (push) last_d = sel_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        imm_mem_q[i] <= 64'd0;
        id_mem_q[i]  <= 1'b0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      if (push) begin
        imm_mem_q[wptr_q] <= gen_imm;
        id_mem_q[wptr_q]  <= sel_id;
      end
    end
  end

  assign out_imm = imm_mem_q[rptr_q];
  assign out_id  = id_mem_q[rptr_q];
  assign occ     = occ_q;

endmodule
